// File: rtl/digit_sequencer_if.sv
// Source-side and driver-side signals of digit_sequencer.
// The bench drives through master; the sequencer attaches as slave.
interface digit_sequencer_if #(
    parameter int CW = 4
);
    logic [3:0]    digit_in;
    logic          digit_valid;
    logic          digit_ready;
    logic          clear;
    logic [3:0]    digit;
    logic          load;
    logic          busy;
    logic [CW-1:0] count;
    logic          reject;

    modport master (
        output digit_in, digit_valid, clear,
        input  digit_ready, digit, load, busy, count, reject
    );

    modport slave (
        input  digit_in, digit_valid, clear,
        output digit_ready, digit, load, busy, count, reject
    );
endinterface

// File: rtl/digit_sequencer.sv
// Queues requested digits and presents each one to step_motor_drive.
// Each digit gets a load-high hold window followed by a load-low re-arm gap.
module digit_sequencer #(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 800_000_000,
    parameter int GAP_CYCLES  = 4_000_000,
    parameter int CW          = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    digit_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   timer_q, timer_d;
    logic [3:0]    digit_q, digit_d;
    logic          load_q, load_d;
    logic          reject_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [3:0]    mem [DEPTH];
    logic          ready, in_range, push, pop;

    // Readiness looks only at the registered count, so a same-cycle pop never frees a slot early.
    assign ready    = count_q < CW'(DEPTH);
    assign in_range = bus.digit_in <= 4'd9;
    assign push     = bus.digit_valid & ready & in_range;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            reject_q <= 1'b0;
        end else begin
            reject_q <= bus.digit_valid & (~ready | ~in_range);
            if (bus.clear) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !bus.clear) mem[wr_ptr_q] <= bus.digit_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            digit_q <= '0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            digit_q <= digit_d;
            load_q  <= load_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        digit_d = digit_q;
        load_d  = load_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                load_d = 1'b0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    digit_d = mem[rd_ptr_q];
                    load_d  = 1'b1;
                    timer_d = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                timer_d = timer_q + 32'd1;
                if (timer_q == 32'(HOLD_CYCLES - 1)) begin
                    load_d  = 1'b0;
                    timer_d = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                timer_d = timer_q + 32'd1;
                if (timer_q == 32'(GAP_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.digit_ready = ready;
    assign bus.digit       = digit_q;
    assign bus.load        = load_q;
    assign bus.busy        = state_q != IDLE;
    assign bus.count       = count_q;
    assign bus.reject      = reject_q;
endmodule

// File: tb/tb_digit_sequencer.sv
// Scoreboard bench for digit_sequencer with short hold/gap timing.
module tb_digit_sequencer;
    localparam int DEPTH = 4;
    localparam int HOLD  = 10;
    localparam int GAP   = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [3:0] d;
        int         c;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;
    int   ncyc  = 0;
    logic prev_load = 1'b0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    digit_sequencer_if #(.CW(CW)) bus ();

    digit_sequencer #(
        .DEPTH(DEPTH),
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES(GAP),
        .CW(CW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Advances to the next negedge and logs every rising load with its digit.
    task automatic step();
        ev_t o;
        @(negedge clk);
        ncyc++;
        if (reset_n === 1'b1 && bus.load === 1'b1 && prev_load !== 1'b1) begin
            o.d = bus.digit;
            o.c = ncyc;
            obs_q.push_back(o);
        end
        prev_load = bus.load;
    endtask

    task automatic run_to(input int target);
        while (ncyc < target) step();
    endtask

    task automatic push_digit(input logic [3:0] d, output logic rej);
        bus.digit_valid = 1'b1;
        bus.digit_in    = d;
        step();
        rej             = bus.reject;
        bus.digit_valid = 1'b0;
        bus.digit_in    = '0;
    endtask

    task automatic expect_load(input logic [3:0] d, input int c);
        ev_t e;
        e.d = d;
        e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        run_to(ncyc + 2);
        total++;
        if ({bus.load, bus.busy, bus.reject, bus.digit, bus.count} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: load=%b busy=%b reject=%b digit=%0d count=%0d, want all 0",
                     bus.load, bus.busy, bus.reject, bus.digit, bus.count);
        end
        reset_n = 1'b1;
        step();
        total++;
        if (bus.digit_ready !== 1'b1 || bus.count !== '0) begin
            bad++;
            $display("FAIL reset_ready: ready=%b count=%0d, want ready=1 count=0", bus.digit_ready, bus.count);
        end
    endtask

    task automatic test_single();
        int t0 = ncyc;
        logic rej;
        ev_t e, o;
        push_digit(4'd4, rej);
        expect_load(4'd4, t0 + 2);
        total++;
        if (rej !== 1'b0) begin bad++; $display("FAIL single_reject: got %b want 0", rej); end
        while (ncyc < t0 + 16) begin
            step();
            if (ncyc == t0 + 2 || ncyc == t0 + 11) begin
                total++;
                if (bus.load !== 1'b1 || bus.digit !== 4'd4) begin
                    bad++;
                    $display("FAIL single_hold: cycle %0d load=%b digit=%0d, want load=1 digit=4", ncyc - t0, bus.load, bus.digit);
                end
            end
            if (ncyc == t0 + 12 || ncyc == t0 + 15) begin
                total++;
                if (bus.load !== 1'b0 || bus.busy !== 1'b1) begin
                    bad++;
                    $display("FAIL single_gap: cycle %0d load=%b busy=%b, want load=0 busy=1", ncyc - t0, bus.load, bus.busy);
                end
            end
        end
        total++;
        if (bus.busy !== 1'b0 || bus.count !== '0 || bus.digit !== 4'd4) begin
            bad++;
            $display("FAIL single_idle: busy=%b count=%0d digit=%0d, want busy=0 count=0 digit=4", bus.busy, bus.count, bus.digit);
        end
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            total++;
            if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); bad++;
                $display("FAIL single_sb: extra load digit=%0d cycle=%0d, want none", o.d, o.c - t0);
            end else if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); bad++;
                $display("FAIL single_sb: no load, want digit=%0d cycle=%0d", e.d, e.c - t0);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.d !== e.d || o.c !== e.c) begin
                    bad++;
                    $display("FAIL single_sb: digit=%0d cycle=%0d, want digit=%0d cycle=%0d", o.d, o.c - t0, e.d, e.c - t0);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int t0 = ncyc;
        logic rej;
        logic [3:0] vals [3] = '{4'd2, 4'd7, 4'd9};
        ev_t e, o;
        for (int i = 0; i < 3; i++) begin
            push_digit(vals[i], rej);
            expect_load(vals[i], t0 + 2 + 15 * i);
        end
        total++;
        if (bus.count !== CW'(2)) begin bad++; $display("FAIL b2b_count: got %0d want 2", bus.count); end
        run_to(t0 + 48);
        total++;
        if (bus.busy !== 1'b0 || bus.count !== '0) begin
            bad++;
            $display("FAIL b2b_idle: busy=%b count=%0d, want 0 0", bus.busy, bus.count);
        end
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            total++;
            if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); bad++;
                $display("FAIL b2b_sb: extra load digit=%0d cycle=%0d, want none", o.d, o.c - t0);
            end else if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); bad++;
                $display("FAIL b2b_sb: no load, want digit=%0d cycle=%0d", e.d, e.c - t0);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.d !== e.d || o.c !== e.c) begin
                    bad++;
                    $display("FAIL b2b_sb: digit=%0d cycle=%0d, want digit=%0d cycle=%0d", o.d, o.c - t0, e.d, e.c - t0);
                end
            end
        end
    endtask

    task automatic test_full();
        int t0 = ncyc;
        int rejects = 0;
        logic rej;
        ev_t e, o;
        push_digit(4'd1, rej);
        expect_load(4'd1, t0 + 2);
        if (rej === 1'b1) rejects++;
        run_to(t0 + 3);
        for (int i = 0; i < 4; i++) begin
            push_digit(4'(5 + i), rej);
            expect_load(4'(5 + i), t0 + 17 + 15 * i);
            if (rej === 1'b1) rejects++;
        end
        total++;
        if (bus.digit_ready !== 1'b0 || bus.count !== CW'(4)) begin
            bad++;
            $display("FAIL full_ready: ready=%b count=%0d, want ready=0 count=4", bus.digit_ready, bus.count);
        end
        push_digit(4'd3, rej);
        if (rej === 1'b1) rejects++;
        total++;
        if (rej !== 1'b1 || bus.count !== CW'(4)) begin
            bad++;
            $display("FAIL full_reject: reject=%b count=%0d, want reject=1 count=4", rej, bus.count);
        end
        step();
        total++;
        if (rejects !== 1 || bus.reject !== 1'b0) begin
            bad++;
            $display("FAIL full_reject_once: pulses=%0d reject_now=%b, want 1 pulse then 0", rejects, bus.reject);
        end
        run_to(t0 + 16);
        total++;
        if (bus.digit_ready !== 1'b0) begin bad++; $display("FAIL full_ready_hold: got %b want 0", bus.digit_ready); end
        step();
        total++;
        if (bus.digit_ready !== 1'b1 || bus.count !== CW'(3)) begin
            bad++;
            $display("FAIL full_ready_pop: ready=%b count=%0d, want ready=1 count=3", bus.digit_ready, bus.count);
        end
        run_to(t0 + 78);
        total++;
        if (bus.busy !== 1'b0 || bus.count !== '0) begin
            bad++;
            $display("FAIL full_idle: busy=%b count=%0d, want 0 0", bus.busy, bus.count);
        end
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            total++;
            if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); bad++;
                $display("FAIL full_sb: extra load digit=%0d cycle=%0d, want none", o.d, o.c - t0);
            end else if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); bad++;
                $display("FAIL full_sb: no load, want digit=%0d cycle=%0d", e.d, e.c - t0);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.d !== e.d || o.c !== e.c) begin
                    bad++;
                    $display("FAIL full_sb: digit=%0d cycle=%0d, want digit=%0d cycle=%0d", o.d, o.c - t0, e.d, e.c - t0);
                end
            end
        end
    endtask

    task automatic test_invalid();
        int t0 = ncyc;
        logic rej;
        logic any_load = 1'b0;
        push_digit(4'd12, rej);
        total++;
        if (rej !== 1'b1 || bus.count !== '0) begin
            bad++;
            $display("FAIL invalid_reject: reject=%b count=%0d, want reject=1 count=0", rej, bus.count);
        end
        step();
        total++;
        if (bus.reject !== 1'b0) begin bad++; $display("FAIL invalid_pulse: reject=%b want 0", bus.reject); end
        while (ncyc < t0 + 8) begin
            step();
            if (bus.load !== 1'b0) any_load = 1'b1;
        end
        total++;
        if (any_load !== 1'b0 || obs_q.size() != 0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL invalid_noload: load_seen=%b rises=%0d busy=%b, want 0 0 0", any_load, obs_q.size(), bus.busy);
        end
        obs_q.delete();
    endtask

    task automatic test_clear();
        int t0 = ncyc;
        logic rej;
        ev_t e, o;
        for (int i = 0; i < 4; i++) push_digit(4'(1 + i), rej);
        expect_load(4'd1, t0 + 2);
        run_to(t0 + 5);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        total++;
        if (bus.count !== '0 || bus.digit_ready !== 1'b1 || bus.load !== 1'b1) begin
            bad++;
            $display("FAIL clear_flush: count=%0d ready=%b load=%b, want 0 1 1", bus.count, bus.digit_ready, bus.load);
        end
        run_to(t0 + 11);
        total++;
        if (bus.load !== 1'b1) begin bad++; $display("FAIL clear_hold: load=%b want 1 at cycle 11", bus.load); end
        step();
        total++;
        if (bus.load !== 1'b0) begin bad++; $display("FAIL clear_fall: load=%b want 0 at cycle 12", bus.load); end
        run_to(t0 + 40);
        total++;
        if (bus.busy !== 1'b0 || bus.digit !== 4'd1) begin
            bad++;
            $display("FAIL clear_idle: busy=%b digit=%0d, want busy=0 digit=1", bus.busy, bus.digit);
        end
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            total++;
            if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); bad++;
                $display("FAIL clear_sb: extra load digit=%0d cycle=%0d, want none", o.d, o.c - t0);
            end else if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); bad++;
                $display("FAIL clear_sb: no load, want digit=%0d cycle=%0d", e.d, e.c - t0);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.d !== e.d || o.c !== e.c) begin
                    bad++;
                    $display("FAIL clear_sb: digit=%0d cycle=%0d, want digit=%0d cycle=%0d", o.d, o.c - t0, e.d, e.c - t0);
                end
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        int t0 = ncyc;
        logic rej;
        ev_t e, o;
        push_digit(4'd6, rej);
        expect_load(4'd6, t0 + 2);
        push_digit(4'd8, rej);
        run_to(t0 + 7);
        reset_n = 1'b0;
        #1;
        total++;
        if ({bus.load, bus.busy, bus.digit, bus.count} !== '0 || bus.digit_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset_outputs: load=%b busy=%b digit=%0d count=%0d ready=%b, want 0 0 0 0 1",
                     bus.load, bus.busy, bus.digit, bus.count, bus.digit_ready);
        end
        run_to(t0 + 9);
        reset_n = 1'b1;
        t0 = ncyc;
        push_digit(4'd3, rej);
        expect_load(4'd3, t0 + 2);
        run_to(t0 + 20);
        total++;
        if (bus.busy !== 1'b0 || bus.count !== '0) begin
            bad++;
            $display("FAIL midreset_idle: busy=%b count=%0d, want 0 0", bus.busy, bus.count);
        end
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            total++;
            if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); bad++;
                $display("FAIL midreset_sb: extra load digit=%0d cycle=%0d, want none", o.d, o.c);
            end else if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); bad++;
                $display("FAIL midreset_sb: no load, want digit=%0d cycle=%0d", e.d, e.c);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.d !== e.d || o.c !== e.c) begin
                    bad++;
                    $display("FAIL midreset_sb: digit=%0d cycle=%0d, want digit=%0d cycle=%0d", o.d, o.c, e.d, e.c);
                end
            end
        end
    endtask

    initial begin
        reset_n         = 1'b1;
        bus.digit_in    = '0;
        bus.digit_valid = 1'b0;
        bus.clear       = 1'b0;
        #2 reset_n = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_invalid();
        test_clear();
        test_reset_mid_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
